// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  // Execute-stage operand source select
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // Controller state: normal flow, waiting on data memory, frozen by watchdog
  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    TIMEOUT
  } hz_state_t;

  // ResultSrc encoding that marks a load
  localparam logic [1:0] RES_LOAD = 2'b01;

  // Pipeline register controls produced each cycle
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } hz_ctl_t;

  // Forward from the youngest in-flight writer; x0 is hard-wired zero and never forwarded
  function automatic fwd_sel_t fwd_select(
    input logic [4:0] rs,
    input logic       wr_m,
    input logic [4:0] rd_m,
    input logic       wr_w,
    input logic [4:0] rd_w
  );
    fwd_sel_t sel;
    sel = FWD_RF;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 64
);
  // Register indices and stage status from the datapath
  logic [4:0]       Rs1_D;
  logic [4:0]       Rs2_D;
  logic [4:0]       Rs1_E;
  logic [4:0]       Rs2_E;
  logic [4:0]       Rd_E;
  logic [4:0]       Rd_M;
  logic [4:0]       Rd_W;
  logic [1:0]       ResultSrc_E;
  logic             RegWrite_E;
  logic             RegWrite_M;
  logic             RegWrite_W;
  logic             PCSrc_E;
  logic             MemReq_M;
  logic             MemReady_M;

  // Pipeline register and forwarding controls
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushW;
  logic [1:0]       ForwardA_E;
  logic [1:0]       ForwardB_E;

  // Watchdog status and performance counters
  logic             MemTimeout;
  logic [CNT_W-1:0] CycleCnt;
  logic [CNT_W-1:0] StallCnt;
  logic [CNT_W-1:0] FlushCnt;
  logic [CNT_W-1:0] MemWaitCnt;

  // Datapath side
  modport master (
    output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W, ResultSrc_E,
    output RegWrite_E, RegWrite_M, RegWrite_W, PCSrc_E, MemReq_M, MemReady_M,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardA_E, ForwardB_E, MemTimeout,
    input  CycleCnt, StallCnt, FlushCnt, MemWaitCnt
  );

  // Hazard controller side
  modport slave (
    input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W, ResultSrc_E,
    input  RegWrite_E, RegWrite_M, RegWrite_W, PCSrc_E, MemReq_M, MemReady_M,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardA_E, ForwardB_E, MemTimeout,
    output CycleCnt, StallCnt, FlushCnt, MemWaitCnt
  );

endinterface

// File: rtl/hazard_perf_ctr.sv
// Free-running event counter, wraps modulo 2^CNT_W.
module hazard_perf_ctr #(
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  // Count enabled cycles; natural overflow gives the wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall / flush / forwarding control for the 5-stage pipeline, with a data-memory
// wait watchdog and hazard performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 256,
  parameter int unsigned CNT_W       = 64
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT) + 1;

  hz_state_t          state;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               mem_timeout;

  logic               memwait;
  logic               loaduse;
  logic               pc_win;
  logic               cnt_active;
  hz_ctl_t            ctl;
  fwd_sel_t           fwd_a;
  fwd_sel_t           fwd_b;

  logic [CNT_W-1:0]   cycle_cnt;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   flush_cnt;
  logic [CNT_W-1:0]   memwait_cnt;

  // Hazard detection from the current stage contents
  always_comb begin
    memwait = hz.MemReq_M && !hz.MemReady_M;
    loaduse = (hz.ResultSrc_E == RES_LOAD) && hz.RegWrite_E && (hz.Rd_E != 5'd0) &&
              ((hz.Rd_E == hz.Rs1_D) || (hz.Rd_E == hz.Rs2_D));
    // A redirect only takes effect when the memory stage is not holding Execute
    pc_win  = hz.PCSrc_E && !memwait && (state != TIMEOUT);
  end

  // Prioritised pipeline control: watchdog freeze, memory wait, redirect, load-use
  always_comb begin
    ctl = '0;
    if (state == TIMEOUT) begin
      ctl.stall_f = 1'b1;
      ctl.stall_d = 1'b1;
      ctl.stall_e = 1'b1;
      ctl.stall_m = 1'b1;
    end else if (memwait) begin
      // Freeze everything up to Memory and drain a bubble into Writeback;
      // a pending redirect or load-use stays visible and is handled after the wait.
      ctl.stall_f = 1'b1;
      ctl.stall_d = 1'b1;
      ctl.stall_e = 1'b1;
      ctl.stall_m = 1'b1;
      ctl.flush_w = 1'b1;
    end else if (hz.PCSrc_E) begin
      // The load-use consumer is on the wrong path, so squashing covers it
      ctl.flush_d = 1'b1;
      ctl.flush_e = 1'b1;
    end else if (loaduse) begin
      ctl.stall_f = 1'b1;
      ctl.stall_d = 1'b1;
      ctl.flush_e = 1'b1;
    end
  end

  // Operand forwarding selects for Execute
  always_comb begin
    fwd_a = fwd_select(hz.Rs1_E, hz.RegWrite_M, hz.Rd_M, hz.RegWrite_W, hz.Rd_W);
    fwd_b = fwd_select(hz.Rs2_E, hz.RegWrite_M, hz.Rd_M, hz.RegWrite_W, hz.Rd_W);
  end

  // Memory-wait watchdog FSM with registered timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          wait_cnt <= '0;
          if (memwait) begin
            state <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (!memwait) begin
            state    <= RUN;
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
            // Flag rises together with the state change, not a cycle later
            state       <= TIMEOUT;
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        TIMEOUT: begin
          mem_timeout <= 1'b1;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Counters freeze once the watchdog has tripped
  assign cnt_active = (state != TIMEOUT);

  hazard_perf_ctr #(
    .CNT_W(CNT_W)
  ) u_cycle_ctr (
    .clk(clk),
    .rst(rst),
    .en (cnt_active),
    .cnt(cycle_cnt)
  );

  hazard_perf_ctr #(
    .CNT_W(CNT_W)
  ) u_stall_ctr (
    .clk(clk),
    .rst(rst),
    .en (cnt_active && ctl.stall_f),
    .cnt(stall_cnt)
  );

  hazard_perf_ctr #(
    .CNT_W(CNT_W)
  ) u_flush_ctr (
    .clk(clk),
    .rst(rst),
    .en (pc_win),
    .cnt(flush_cnt)
  );

  hazard_perf_ctr #(
    .CNT_W(CNT_W)
  ) u_memwait_ctr (
    .clk(clk),
    .rst(rst),
    .en (cnt_active && memwait),
    .cnt(memwait_cnt)
  );

  assign hz.StallF     = ctl.stall_f;
  assign hz.StallD     = ctl.stall_d;
  assign hz.StallE     = ctl.stall_e;
  assign hz.StallM     = ctl.stall_m;
  assign hz.FlushD     = ctl.flush_d;
  assign hz.FlushE     = ctl.flush_e;
  assign hz.FlushW     = ctl.flush_w;
  assign hz.ForwardA_E = fwd_a;
  assign hz.ForwardB_E = fwd_b;
  assign hz.MemTimeout = mem_timeout;
  assign hz.CycleCnt   = cycle_cnt;
  assign hz.StallCnt   = stall_cnt;
  assign hz.FlushCnt   = flush_cnt;
  assign hz.MemWaitCnt = memwait_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a run-length based reference model.
module tb_hazard_ctrl;

  localparam int unsigned MemTo = 4;
  localparam int unsigned CntW  = 64;

  logic clk = 1'b0;
  logic rst;

  hazard_ctrl_if #(.CNT_W(CntW)) hz ();

  hazard_ctrl #(
    .MEM_TIMEOUT(MemTo),
    .CNT_W      (CntW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit              m_to;
  int              m_run;
  longint unsigned m_cyc, m_stall, m_flush, m_memw;

  logic [6:0] ctl_obs;
  assign ctl_obs = {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushW};

  // Expected {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  function automatic logic [6:0] ref_ctl();
    logic mw, lu;
    mw = hz.MemReq_M && !hz.MemReady_M;
    lu = (hz.ResultSrc_E == 2'b01) && hz.RegWrite_E && (hz.Rd_E != 0) &&
         ((hz.Rd_E == hz.Rs1_D) || (hz.Rd_E == hz.Rs2_D));
    if (m_to) return 7'b1111000;
    if (mw) return 7'b1111001;
    if (hz.PCSrc_E) return 7'b0000110;
    if (lu) return 7'b1100010;
    return 7'b0000000;
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (hz.RegWrite_M && hz.Rd_M != 0 && hz.Rd_M == rs) return 2'b10;
    if (hz.RegWrite_W && hz.Rd_W != 0 && hz.Rd_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_clear();
    m_to = 0; m_run = 0; m_cyc = 0; m_stall = 0; m_flush = 0; m_memw = 0;
  endtask

  task automatic idle_inputs();
    hz.Rs1_D = 0; hz.Rs2_D = 0; hz.Rs1_E = 0; hz.Rs2_E = 0;
    hz.Rd_E = 0; hz.Rd_M = 0; hz.Rd_W = 0; hz.ResultSrc_E = 0;
    hz.RegWrite_E = 0; hz.RegWrite_M = 0; hz.RegWrite_W = 0;
    hz.PCSrc_E = 0; hz.MemReq_M = 0; hz.MemReady_M = 0;
  endtask

  // Advance the model for the coming edge, then move to just after it
  task automatic tick();
    logic [6:0] c;
    logic mw;
    c  = ref_ctl();
    mw = hz.MemReq_M && !hz.MemReady_M;
    if (!m_to) begin
      m_cyc++;
      if (c[6]) m_stall++;
      if (hz.PCSrc_E && !mw) m_flush++;
      if (mw) begin
        m_memw++;
        m_run++;
        if (m_run == int'(MemTo) + 1) m_to = 1;
      end else begin
        m_run = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    model_clear();
    #2;
    checks++;
    if (ctl_obs !== 7'b0) begin
      errors++; $display("FAIL reset_ctl: got %b expected %b", ctl_obs, 7'b0);
    end
    checks++;
    if (hz.MemTimeout !== 1'b0) begin
      errors++; $display("FAIL reset_timeout: got %b expected 0", hz.MemTimeout);
    end
    checks++;
    if ({hz.CycleCnt, hz.StallCnt, hz.FlushCnt, hz.MemWaitCnt} !== '0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d/%0d/%0d expected 0", hz.CycleCnt,
                         hz.StallCnt, hz.FlushCnt, hz.MemWaitCnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_forwarding();
    do_reset();
    hz.RegWrite_M = 1; hz.Rd_M = 5; hz.RegWrite_W = 1; hz.Rd_W = 5; hz.Rs1_E = 5;
    settle();
    checks++;
    if (hz.ForwardA_E !== 2'b10) begin
      errors++; $display("FAIL fwd_mem_prio: got %b expected 10", hz.ForwardA_E);
    end
    hz.Rd_M = 0;
    settle();
    checks++;
    if (hz.ForwardA_E !== 2'b01) begin
      errors++; $display("FAIL fwd_wb: got %b expected 01", hz.ForwardA_E);
    end
    hz.Rd_M = 5; hz.RegWrite_M = 0; hz.Rs2_E = 5;
    settle();
    checks++;
    if (hz.ForwardB_E !== 2'b01) begin
      errors++; $display("FAIL fwd_b_wb_nowr: got %b expected 01", hz.ForwardB_E);
    end
    hz.RegWrite_M = 1; hz.Rd_M = 0; hz.Rd_W = 0; hz.Rs2_E = 0; hz.Rs1_E = 0;
    settle();
    checks++;
    if ({hz.ForwardA_E, hz.ForwardB_E} !== 4'b0000) begin
      errors++; $display("FAIL fwd_x0: got %b%b expected 0000", hz.ForwardA_E, hz.ForwardB_E);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    hz.ResultSrc_E = 2'b01; hz.RegWrite_E = 1; hz.Rd_E = 7; hz.Rs2_D = 7;
    settle();
    checks++;
    if (ctl_obs !== 7'b1100010) begin
      errors++; $display("FAIL lu_ctl: got %b expected %b", ctl_obs, 7'b1100010);
    end
    tick();
    idle_inputs();
    settle();
    checks++;
    if (ctl_obs !== 7'b0) begin
      errors++; $display("FAIL lu_release: got %b expected 0", ctl_obs);
    end
    checks++;
    if (hz.StallCnt !== 64'd1 || hz.CycleCnt !== 64'd1) begin
      errors++; $display("FAIL lu_cnt: got stall %0d cycle %0d expected 1 1", hz.StallCnt,
                         hz.CycleCnt);
    end
  endtask

  task automatic test_branch_vs_loaduse();
    do_reset();
    hz.ResultSrc_E = 2'b01; hz.RegWrite_E = 1; hz.Rd_E = 9; hz.Rs1_D = 9; hz.PCSrc_E = 1;
    settle();
    checks++;
    if (ctl_obs !== 7'b0000110) begin
      errors++; $display("FAIL br_lu_ctl: got %b expected %b", ctl_obs, 7'b0000110);
    end
    tick();
    idle_inputs();
    settle();
    checks++;
    if (hz.FlushCnt !== 64'd1 || hz.StallCnt !== 64'd0) begin
      errors++; $display("FAIL br_lu_cnt: got flush %0d stall %0d expected 1 0", hz.FlushCnt,
                         hz.StallCnt);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    hz.MemReq_M = 1; hz.MemReady_M = 0; hz.PCSrc_E = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if (ctl_obs !== 7'b1111001) begin
        errors++; $display("FAIL mw_ctl[%0d]: got %b expected %b", i, ctl_obs, 7'b1111001);
      end
      tick();
    end
    hz.MemReady_M = 1; hz.PCSrc_E = 0;
    settle();
    checks++;
    if (ctl_obs !== 7'b0) begin
      errors++; $display("FAIL mw_done: got %b expected 0", ctl_obs);
    end
    tick();
    idle_inputs();
    settle();
    checks++;
    if (hz.MemWaitCnt !== 64'd3 || hz.StallCnt !== 64'd3 || hz.FlushCnt !== 64'd0) begin
      errors++; $display("FAIL mw_cnt: got memwait %0d stall %0d flush %0d expected 3 3 0",
                         hz.MemWaitCnt, hz.StallCnt, hz.FlushCnt);
    end
    // A fresh 4-cycle wait must not inherit the earlier wait count
    hz.MemReq_M = 1;
    for (int i = 0; i < 4; i++) tick();
    hz.MemReady_M = 1;
    tick();
    idle_inputs();
    settle();
    checks++;
    if (hz.MemTimeout !== 1'b0) begin
      errors++; $display("FAIL mw_run_restart: got timeout %b expected 0", hz.MemTimeout);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    hz.MemReq_M = 1; hz.MemReady_M = 0;
    for (int i = 0; i < 5; i++) begin
      settle();
      checks++;
      if (hz.MemTimeout !== 1'b0) begin
        errors++; $display("FAIL wd_early[%0d]: got %b expected 0", i, hz.MemTimeout);
      end
      tick();
    end
    settle();
    checks++;
    if (hz.MemTimeout !== 1'b1 || ctl_obs !== 7'b1111000) begin
      errors++; $display("FAIL wd_trip: got timeout %b ctl %b expected 1 %b", hz.MemTimeout,
                         ctl_obs, 7'b1111000);
    end
    hz.MemReq_M = 0;
    tick();
    tick();
    settle();
    checks++;
    if (hz.MemTimeout !== 1'b1 || ctl_obs !== 7'b1111000) begin
      errors++; $display("FAIL wd_sticky: got timeout %b ctl %b expected 1 %b", hz.MemTimeout,
                         ctl_obs, 7'b1111000);
    end
    checks++;
    if (hz.CycleCnt !== 64'd5 || hz.MemWaitCnt !== 64'd5 || hz.StallCnt !== 64'd5) begin
      errors++; $display("FAIL wd_frozen_cnt: got %0d/%0d/%0d expected 5/5/5", hz.CycleCnt,
                         hz.MemWaitCnt, hz.StallCnt);
    end
    rst = 1'b1;
    model_clear();
    #1;
    checks++;
    if (hz.MemTimeout !== 1'b0 || ctl_obs !== 7'b0 || hz.CycleCnt !== 64'd0) begin
      errors++; $display("FAIL wd_reset: got timeout %b ctl %b cycle %0d expected 0 0 0",
                         hz.MemTimeout, ctl_obs, hz.CycleCnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    hz.MemReq_M = 1; hz.MemReady_M = 0;
    tick();
    tick();
    rst = 1'b1;
    idle_inputs();
    model_clear();
    #1;
    checks++;
    if (ctl_obs !== 7'b0 || hz.MemTimeout !== 1'b0) begin
      errors++; $display("FAIL rmw_out: got ctl %b timeout %b expected 0 0", ctl_obs,
                         hz.MemTimeout);
    end
    checks++;
    if ({hz.CycleCnt, hz.StallCnt, hz.FlushCnt, hz.MemWaitCnt} !== '0) begin
      errors++; $display("FAIL rmw_cnt: got %0d/%0d/%0d/%0d expected 0", hz.CycleCnt,
                         hz.StallCnt, hz.FlushCnt, hz.MemWaitCnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Wait counter must have been discarded: 4 more waits stay below the limit
    hz.MemReq_M = 1;
    for (int i = 0; i < 4; i++) tick();
    settle();
    checks++;
    if (hz.MemTimeout !== 1'b0) begin
      errors++; $display("FAIL rmw_discard: got timeout %b expected 0", hz.MemTimeout);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [6:0] e_ctl;
    logic [1:0] e_a, e_b;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (m_to && ($urandom_range(0, 3) == 0)) do_reset();
      hz.Rs1_D = 5'($urandom_range(0, 3)); hz.Rs2_D = 5'($urandom_range(0, 3));
      hz.Rs1_E = 5'($urandom_range(0, 3)); hz.Rs2_E = 5'($urandom_range(0, 3));
      hz.Rd_E  = 5'($urandom_range(0, 3)); hz.Rd_M  = 5'($urandom_range(0, 3));
      hz.Rd_W  = 5'($urandom_range(0, 3));
      hz.ResultSrc_E = 2'($urandom_range(0, 3));
      hz.RegWrite_E = 1'($urandom); hz.RegWrite_M = 1'($urandom);
      hz.RegWrite_W = 1'($urandom);
      hz.PCSrc_E    = ($urandom_range(0, 3) == 0);
      hz.MemReq_M   = ($urandom_range(0, 2) == 0) || (m_run > 0 && $urandom_range(0, 2) != 0);
      hz.MemReady_M = ($urandom_range(0, 2) == 0);
      settle();
      e_ctl = ref_ctl();
      e_a   = ref_fwd(hz.Rs1_E);
      e_b   = ref_fwd(hz.Rs2_E);
      checks++;
      if (ctl_obs !== e_ctl) begin
        errors++; $display("FAIL rnd_ctl[%0d]: got %b expected %b", n, ctl_obs, e_ctl);
      end
      checks++;
      if (hz.ForwardA_E !== e_a) begin
        errors++; $display("FAIL rnd_fwd_a[%0d]: got %b expected %b", n, hz.ForwardA_E, e_a);
      end
      checks++;
      if (hz.ForwardB_E !== e_b) begin
        errors++; $display("FAIL rnd_fwd_b[%0d]: got %b expected %b", n, hz.ForwardB_E, e_b);
      end
      checks++;
      if (hz.MemTimeout !== m_to) begin
        errors++; $display("FAIL rnd_timeout[%0d]: got %b expected %b", n, hz.MemTimeout, m_to);
      end
      checks++;
      if (hz.CycleCnt !== m_cyc || hz.StallCnt !== m_stall) begin
        errors++; $display("FAIL rnd_cnt_a[%0d]: got %0d/%0d expected %0d/%0d", n, hz.CycleCnt,
                           hz.StallCnt, m_cyc, m_stall);
      end
      checks++;
      if (hz.FlushCnt !== m_flush || hz.MemWaitCnt !== m_memw) begin
        errors++; $display("FAIL rnd_cnt_b[%0d]: got %0d/%0d expected %0d/%0d", n, hz.FlushCnt,
                           hz.MemWaitCnt, m_flush, m_memw);
      end
      tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_vs_loaduse();
    test_mem_wait();
    test_watchdog();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV64I+Zba core. It generates the stall, flush and operand-forwarding controls for the F/D, D/E, E/M and M/W pipeline registers from the register indices, load/branch status and data-memory handshake. It supervises data-memory wait cycles with a watchdog and keeps hazard performance counters. It sits beside the datapath; its outputs drive the enable and synchronous-clear inputs of each pipeline register and the forwarding muxes in Execute.

## Interface

- `MEM_TIMEOUT`, default 256: maximum consecutive memory-wait cycles before the watchdog trips.
- `CNT_W`, default 64: performance counter width.

Reset is asynchronous and active-high.

- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `Rs1_D`, `Rs2_D` in 5: source registers in Decode.
- `Rs1_E`, `Rs2_E`, `Rd_E` in 5: source and destination registers in Execute.
- `Rd_M`, `Rd_W` in 5: destination registers in Memory and Writeback.
- `ResultSrc_E` in 2: value 2'b01 marks a load in Execute.
- `RegWrite_E`, `RegWrite_M`, `RegWrite_W` in 1: register-write enables per stage.
- `PCSrc_E` in 1: taken branch or jump resolved in Execute.
- `MemReq_M` in 1: data-memory access active in Memory.
- `MemReady_M` in 1: data memory completes the access this cycle.
- `StallF`, `StallD`, `StallE`, `StallM` out 1: hold the PC, F/D, D/E and E/M registers.
- `FlushD`, `FlushE`, `FlushW` out 1: clear F/D, D/E and M/W to a bubble (all controls 0).
- `ForwardA_E`, `ForwardB_E` out 2: operand select. 2'b00 selects the register file, 2'b10 selects the Memory ALU result, 2'b01 selects the Writeback result.
- `MemTimeout` out 1: sticky watchdog error.
- `CycleCnt`, `StallCnt`, `FlushCnt`, `MemWaitCnt` out `CNT_W`: performance counters.

## Operation

- **Forwarding (combinational), for each of Rs1_E and Rs2_E:**
  - If RegWrite_M, Rd_M≠0 and Rd_M equals the source: select 2'b10.
  - Else if RegWrite_W, Rd_W≠0 and Rd_W equals the source: select 2'b01.
  - Else select 2'b00.
  - Memory takes priority over Writeback. x0 is never forwarded.
- **memwait** = MemReq_M && !MemReady_M.
- **loaduse** = (ResultSrc_E==2'b01) && RegWrite_E && Rd_E≠0 && (Rd_E==Rs1_D || Rd_E==Rs2_D).
- **Control priority, highest first:**
  1. State TIMEOUT: all Stall* = 1, all Flush* = 0. The pipeline is frozen until reset.
  2. memwait: StallF/D/E/M = 1, FlushW = 1 (bubble into Writeback), FlushD = FlushE = 0. PCSrc_E and loaduse are deferred, because Execute is frozen and both persist.
  3. PCSrc_E: FlushD = FlushE = 1, no stalls. loaduse is ignored because the dependent instruction is squashed.
  4. loaduse: StallF = StallD = 1, FlushE = 1.
  5. Otherwise all controls are 0.
- **FSM states:**
  - RUN → MEM_WAIT on memwait.
  - MEM_WAIT → RUN when MemReady_M or !MemReq_M.
  - MEM_WAIT → TIMEOUT when the wait counter reaches MEM_TIMEOUT−1 while memwait persists.
  - TIMEOUT is absorbing; only rst leaves it.
- **Wait counter:** cleared in RUN, incremented each MEM_WAIT cycle. Width is $clog2(MEM_TIMEOUT)+1.
- **MemTimeout** = (state==TIMEOUT), registered.
- **Counters:** wrap modulo 2^CNT_W with no saturation, and do not count in TIMEOUT.
  - CycleCnt increments every cycle.
  - StallCnt increments on any cycle with StallF=1.
  - FlushCnt increments on each cycle with PCSrc_E winning priority.
  - MemWaitCnt increments each memwait cycle.

## Timing

- Stall, flush and forward outputs are combinational from the current inputs and state, and act on the next clock edge.
- A load-use hazard costs exactly 1 bubble. A taken branch costs 2 squashed instructions.
- A memory wait of N cycles produces N cycles of stall and N Writeback bubbles. The access completes on the cycle MemReady_M=1, with no extra cycle.
- FSM, wait counter, MemTimeout and counters are registered, updating on posedge clk.
- MEM_WAIT is entered one cycle after memwait is first seen. With MEM_TIMEOUT=256, MemTimeout rises on the edge ending the 257th consecutive wait cycle.
- **Reset values:** state RUN, wait counter 0, MemTimeout 0, all counters 0. Combinational outputs follow from those: all 0 when inputs are idle.
- **Reset mid-wait:** returns to RUN immediately (asynchronous) and discards the counter.
- **Simultaneous memwait and MemReady_M:** impossible by definition, since memwait requires !MemReady_M.
- **Simultaneous PCSrc_E and loaduse:** flush only.

## Structure

- `hazard_pkg` holds:
  - `fwd_sel_t` (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10);
  - `hz_state_t` (RUN, MEM_WAIT, TIMEOUT);
  - `RES_LOAD`=2'b01.
- Sub-module `hazard_perf_ctr`: one parameterised `CNT_W` counter with `rst`, `en` and `cnt` ports, instantiated four times.

## Test plan

- **Forwarding:** Rd_M=5 with RegWrite_M, Rd_W=5 with RegWrite_W, Rs1_E=5 → ForwardA_E=2'b10. With Rd_M=0 instead → 2'b01. With Rs2_E=0 and all writers targeting x0 → ForwardB_E=2'b00.
- **Load-use:** ResultSrc_E=01, Rd_E=7, Rs2_D=7 → StallF=StallD=FlushE=1 for one cycle. StallCnt advances by 1.
- **Branch vs load-use:** PCSrc_E=1 together with a load-use match → FlushD=FlushE=1, StallF=0. FlushCnt advances by 1.
- **Memory wait:** MemReq_M=1, MemReady_M low for 3 cycles then high → StallF/D/E/M=FlushW=1 for 3 cycles, then all 0. MemWaitCnt=3. State returns to RUN.
- **Watchdog:** MEM_TIMEOUT=4, MemReady_M held low → MemTimeout=1 after the 5th wait cycle and stays 1 after MemReq_M drops. All stalls remain high. Asserting rst clears everything.
- **Reset mid-wait:** rst pulsed in MEM_WAIT → all outputs and counters read 0 in the same cycle.
